// File: rtl/is_array_ctrl.sv
// ---------------------------------------------------------------------------
// is_array_ctrl
// Sequencer for an input-stationary PE array. One job runs
// IDLE -> CLEAR -> LOAD -> STREAM -> FLUSH -> DRAIN -> DONE -> IDLE.
// It clears the PE registers, preloads activations (2 cycles per column),
// streams k_len weight vectors and flushes the pipeline. It then scans out
// the MAC results and pulses done.
//
// Parameters: ROWS, COLS, STAGE (PE pipeline depth), KW (k_len width).
// Inputs : clk, rst_n (async, active-low), start, k_len[KW-1:0], stall, abort
// Outputs: reg_clear, cell_sc_en, act_rd_en, wei_rd_en, pipeline_en,
//          cell_en[ROWS-1:0] (row-skewed), cscan_en, busy, done, err
// Optional: define IS_ARRAY_CTRL_PERF_EN to add perf_cycles[31:0] and
//          perf_stalls[31:0]. They report the busy and stalled cycle counts
//          of the last job.
// ---------------------------------------------------------------------------
module is_array_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int STAGE = 0,
  parameter int KW    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  input  logic            stall,
  input  logic            abort,
`ifdef IS_ARRAY_CTRL_PERF_EN
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_stalls,
`endif
  output logic            reg_clear,
  output logic            cell_sc_en,
  output logic            act_rd_en,
  output logic            wei_rd_en,
  output logic            pipeline_en,
  output logic [ROWS-1:0] cell_en,
  output logic            cscan_en,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int LOAD_N  = 2 * COLS;
  localparam int FLUSH_N = ROWS + COLS + STAGE;
  localparam int LW      = $clog2(LOAD_N + 1);
  localparam int FW      = $clog2(FLUSH_N + 1);
  localparam int CW      = (KW > LW) ? ((KW > FW) ? KW : FW) : ((LW > FW) ? LW : FW);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LOAD   = 3'd2,
    S_STREAM = 3'd3,
    S_FLUSH  = 3'd4,
    S_DRAIN  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [KW-1:0]   k_m1_r;        // k_len - 1, reloaded into cnt_r on entry to STREAM
  logic [ROWS-2:0] skew_r;        // skew_r[i] drives cell_en[i+1]
  logic            abort_clr_r;   // reg_clear in the cycle after an abort
  logic            err_r;
  logic            busy_s;
  logic            cnt_zero_s;
  logic            kill_s;
  logic            accept_s;

  assign busy_s     = (state_r != S_IDLE);
  assign cnt_zero_s = (cnt_r == {CW{1'b0}});
  assign kill_s     = abort & busy_s;
  assign accept_s   = (state_r == S_IDLE) & start & (k_len != {KW{1'b0}});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort overrides everything, including stall
  always_comb begin
    state_nxt_s = state_r;
    if (kill_s) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE:   state_nxt_s = accept_s ? S_CLEAR : S_IDLE;
        S_CLEAR:  state_nxt_s = S_LOAD;
        S_LOAD:   state_nxt_s = cnt_zero_s ? S_STREAM : S_LOAD;
        S_STREAM: state_nxt_s = (!stall && cnt_zero_s) ? S_FLUSH : S_STREAM;
        S_FLUSH:  state_nxt_s = (!stall && cnt_zero_s) ? S_DRAIN : S_FLUSH;
        S_DRAIN:  state_nxt_s = (!stall && cnt_zero_s) ? S_DONE : S_DRAIN;
        S_DONE:   state_nxt_s = S_IDLE;
        default:  state_nxt_s = S_IDLE;
      endcase
    end
  end

  // Output decode; stall gates the advance strobes in the same cycle
  always_comb begin
    reg_clear   = (state_r == S_CLEAR) | abort_clr_r;
    cell_sc_en  = (state_r == S_LOAD);
    act_rd_en   = (state_r == S_LOAD);
    wei_rd_en   = (state_r == S_STREAM) & ~stall;
    pipeline_en = ((state_r == S_STREAM) | (state_r == S_FLUSH)) & ~stall;
    cscan_en    = (state_r == S_DRAIN) & ~stall;
    busy        = busy_s;
    done        = (state_r == S_DONE);
    err         = err_r;
    cell_en     = {skew_r, (state_r == S_STREAM) & ~stall};
  end

  // Phase down-counter: holds (length - 1) of the current phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (kill_s) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      case (state_r)
        S_CLEAR:  cnt_r <= CW'(LOAD_N - 1);
        S_LOAD:   cnt_r <= cnt_zero_s ? CW'(k_m1_r) : cnt_r - CW'(1'b1);
        S_STREAM: begin
          if (stall)           cnt_r <= cnt_r;
          else if (cnt_zero_s) cnt_r <= CW'(FLUSH_N - 1);
          else                 cnt_r <= cnt_r - CW'(1'b1);
        end
        S_FLUSH: begin
          if (stall)           cnt_r <= cnt_r;
          else if (cnt_zero_s) cnt_r <= CW'(ROWS - 1);
          else                 cnt_r <= cnt_r - CW'(1'b1);
        end
        S_DRAIN:  cnt_r <= (stall || cnt_zero_s) ? cnt_r : cnt_r - CW'(1'b1);
        default:  cnt_r <= {CW{1'b0}};
      endcase
    end
  end

  // Job length latch, job-reject pulse and post-abort clear flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_m1_r      <= {KW{1'b0}};
      err_r       <= 1'b0;
      abort_clr_r <= 1'b0;
    end else begin
      k_m1_r      <= accept_s ? (k_len - KW'(1'b1)) : k_m1_r;
      err_r       <= (state_r == S_IDLE) & start & (k_len == {KW{1'b0}});
      abort_clr_r <= kill_s;
    end
  end

  // Row skew: cell_en[r] follows cell_en[r-1] one pipeline advance later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skew_r <= {(ROWS-1){1'b0}};
    end else if (kill_s) begin
      skew_r <= {(ROWS-1){1'b0}};
    end else if (pipeline_en) begin
      skew_r <= cell_en[ROWS-2:0];
    end else begin
      skew_r <= skew_r;
    end
  end

`ifdef IS_ARRAY_CTRL_PERF_EN
  // Per-job busy and stall counters; stop counting once the FSM is back in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= 32'd0;
      perf_stalls <= 32'd0;
    end else if (accept_s) begin
      perf_cycles <= 32'd0;
      perf_stalls <= 32'd0;
    end else if (busy_s) begin
      perf_cycles <= perf_cycles + 32'd1;
      if (stall && !abort &&
          ((state_r == S_STREAM) || (state_r == S_FLUSH) || (state_r == S_DRAIN))) begin
        perf_stalls <= perf_stalls + 32'd1;
      end else begin
        perf_stalls <= perf_stalls;
      end
    end else begin
      perf_cycles <= perf_cycles;
      perf_stalls <= perf_stalls;
    end
  end
`endif

endmodule
